// File: rtl/redun_to_binary_serializer.sv
// Drains a redundant-form coefficient vector into canonical WORD_LEN-bit words, LSW first,
// resolving carries one coefficient per cycle and presenting words on a valid/ready stream.
module redun_to_binary_serializer #(
    parameter int NUM_ELEMENTS = 66,
    parameter int DSP_BIT_LEN  = 17,
    parameter int WORD_LEN     = 16,
    parameter bit EMIT_CARRY   = 1'b1,
    localparam int IDX_W = $clog2(NUM_ELEMENTS + 1)
) (
    input  logic                                        i_clk,
    input  logic                                        i_rst,
    input  logic                                        i_val,
    output logic                                        o_rdy,
    input  logic [NUM_ELEMENTS-1:0][DSP_BIT_LEN-1:0]    i_dat,
    output logic                                        o_val,
    input  logic                                        i_rdy,
    output logic [WORD_LEN-1:0]                         o_dat,
    output logic [IDX_W-1:0]                            o_idx,
    output logic                                        o_last,
    output logic                                        o_ovf,
    output logic [1:0]                                  o_state
);

    localparam int CARRY_LEN = DSP_BIT_LEN - WORD_LEN + 1;
    localparam int SUM_W     = DSP_BIT_LEN + 1;
    localparam int SEL_W     = (NUM_ELEMENTS > 1) ? $clog2(NUM_ELEMENTS) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_CARRY  = 2'd2
    } state_t;

    state_t                                   state;
    logic [NUM_ELEMENTS-1:0][DSP_BIT_LEN-1:0] coef_buf;
    logic [IDX_W-1:0]                         idx;
    logic [CARRY_LEN-1:0]                     carry;

    logic [SEL_W-1:0]       rd_sel;
    logic [IDX_W-1:0]       cur_idx;
    logic [DSP_BIT_LEN-1:0] cur_coef;
    logic [CARRY_LEN-1:0]   cur_carry;
    logic [SUM_W-1:0]       sum;
    logic [CARRY_LEN-1:0]   carry_next;
    logic                   is_final;
    logic                   more_data;
    logic                   advance;
    logic                   accept;
    logic                   load_word;
    logic                   load_carry;
    logic                   finish;

    // Handshake: input vector moves on i_val && o_rdy; output word moves on o_val && i_rdy,
    // and o_val/o_dat/o_idx/o_last/o_ovf hold steady while o_val && !i_rdy.
    assign o_rdy   = (state == S_IDLE);
    assign o_state = state;
    assign rd_sel  = idx[SEL_W-1:0];

    // The acceptance cycle resolves word 0 straight from i_dat so it is valid one cycle later.
    always_comb begin
        cur_idx    = '0;
        cur_coef   = i_dat[0];
        cur_carry  = '0;
        if (state != S_IDLE) begin
            cur_idx   = idx;
            cur_coef  = coef_buf[rd_sel];
            cur_carry = carry;
        end
        sum        = {1'b0, cur_coef} + SUM_W'(cur_carry);
        carry_next = sum[SUM_W-1:WORD_LEN];
        is_final   = (cur_idx == IDX_W'(NUM_ELEMENTS - 1));
        more_data  = (idx != IDX_W'(NUM_ELEMENTS));
        advance    = !o_val || i_rdy;
        accept     = (state == S_IDLE) && i_val;
        load_word  = accept || ((state == S_STREAM) && advance && !o_last && more_data);
        load_carry = (state == S_STREAM) && advance && !o_last && !more_data;
        finish     = o_val && i_rdy && o_last;
    end

    always_ff @(posedge i_clk) begin
        if (accept) begin
            coef_buf <= i_dat;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state  <= S_IDLE;
            idx    <= '0;
            carry  <= '0;
            o_val  <= 1'b0;
            o_dat  <= '0;
            o_idx  <= '0;
            o_last <= 1'b0;
            o_ovf  <= 1'b0;
        end else if (load_word) begin
            state  <= S_STREAM;
            idx    <= cur_idx + IDX_W'(1);
            carry  <= carry_next;
            o_val  <= 1'b1;
            o_dat  <= sum[WORD_LEN-1:0];
            o_idx  <= cur_idx;
            o_last <= !EMIT_CARRY && is_final;
            o_ovf  <= !EMIT_CARRY && is_final && (carry_next != '0);
        end else if (load_carry) begin
            state  <= S_CARRY;
            o_val  <= 1'b1;
            o_dat  <= WORD_LEN'(carry);
            o_idx  <= IDX_W'(NUM_ELEMENTS);
            o_last <= 1'b1;
            o_ovf  <= 1'b0;
        end else if (finish) begin
            state  <= S_IDLE;
            o_val  <= 1'b0;
            o_last <= 1'b0;
            o_ovf  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_redun_to_binary_serializer.sv
// Bench for redun_to_binary_serializer: two 4-element instances (carry word / overflow flag)
// and one default-sized instance, checked against table vectors and a big-integer model.
module tb_redun_to_binary_serializer;

    typedef struct packed {
        logic [15:0] dat;
        logic [6:0]  idx;
        logic        last;
        logic        ovf;
    } word_t;

    typedef struct {
        logic [3:0][16:0] coef;
        logic [4:0][15:0] words;
        logic             ovf;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic rnd_en;
    int   checks = 0;
    int   errors = 0;
    int   xfer_d = 0;

    logic [3:0][16:0]  dat4;
    logic [65:0][16:0] datd;
    logic val4c, val4n, vald;
    logic rdy4c, rdy4n, rdyd;

    logic o_rdy4c, o_val4c, o_last4c, o_ovf4c;
    logic [15:0] o_dat4c;
    logic [2:0]  o_idx4c;
    logic [1:0]  st4c;
    logic o_rdy4n, o_val4n, o_last4n, o_ovf4n;
    logic [15:0] o_dat4n;
    logic [2:0]  o_idx4n;
    logic [1:0]  st4n;
    logic o_rdyd, o_vald, o_lastd, o_ovfd;
    logic [15:0] o_datd;
    logic [6:0]  o_idxd;
    logic [1:0]  std;

    word_t g4c, g4n, gd, p4c, p4n, pd;
    logic  hold4c = 1'b0, hold4n = 1'b0, holdd = 1'b0;
    word_t q4c[$], q4n[$], qd[$];
    vec_t  tbl[5];

    assign g4c = {o_dat4c, {4'b0, o_idx4c}, o_last4c, o_ovf4c};
    assign g4n = {o_dat4n, {4'b0, o_idx4n}, o_last4n, o_ovf4n};
    assign gd  = {o_datd, o_idxd, o_lastd, o_ovfd};

    redun_to_binary_serializer #(.NUM_ELEMENTS(4), .EMIT_CARRY(1'b1)) dut4c (
        .i_clk(clk), .i_rst(rst), .i_val(val4c), .o_rdy(o_rdy4c), .i_dat(dat4),
        .o_val(o_val4c), .i_rdy(rdy4c), .o_dat(o_dat4c), .o_idx(o_idx4c),
        .o_last(o_last4c), .o_ovf(o_ovf4c), .o_state(st4c)
    );

    redun_to_binary_serializer #(.NUM_ELEMENTS(4), .EMIT_CARRY(1'b0)) dut4n (
        .i_clk(clk), .i_rst(rst), .i_val(val4n), .o_rdy(o_rdy4n), .i_dat(dat4),
        .o_val(o_val4n), .i_rdy(rdy4n), .o_dat(o_dat4n), .o_idx(o_idx4n),
        .o_last(o_last4n), .o_ovf(o_ovf4n), .o_state(st4n)
    );

    redun_to_binary_serializer dutd (
        .i_clk(clk), .i_rst(rst), .i_val(vald), .o_rdy(o_rdyd), .i_dat(datd),
        .o_val(o_vald), .i_rdy(rdyd), .o_dat(o_datd), .o_idx(o_idxd),
        .o_last(o_lastd), .o_ovf(o_ovfd), .o_state(std)
    );

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Downstream ready: random when rnd_en, otherwise held high.
    initial begin
        rdy4c = 1'b1; rdy4n = 1'b1; rdyd = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (rnd_en) begin
                rdy4c = 1'($urandom_range(0, 1));
                rdy4n = 1'($urandom_range(0, 1));
                rdyd  = 1'($urandom_range(0, 1));
            end else begin
                rdy4c = 1'b1; rdy4n = 1'b1; rdyd = 1'b1;
            end
        end
    end

    // Scoreboard: stall stability plus in-order compare of every transferred word.
    always @(negedge clk) begin : mon
        word_t e;
        if (hold4c) chk(o_val4c && g4c == p4c, "hold_4c", g4c, p4c);
        if (hold4n) chk(o_val4n && g4n == p4n, "hold_4n", g4n, p4n);
        if (holdd)  chk(o_vald && gd == pd, "hold_d", gd, pd);
        if (o_val4c && rdy4c && !rst) begin
            if (q4c.size() == 0) chk(1'b0, "extra_4c", g4c, 0);
            else begin e = q4c.pop_front(); chk(g4c == e, "word_4c", g4c, e); end
        end
        if (o_val4n && rdy4n && !rst) begin
            if (q4n.size() == 0) chk(1'b0, "extra_4n", g4n, 0);
            else begin e = q4n.pop_front(); chk(g4n == e, "word_4n", g4n, e); end
        end
        if (o_vald && rdyd && !rst) begin
            xfer_d <= xfer_d + 1;
            if (qd.size() == 0) chk(1'b0, "extra_d", gd, 0);
            else begin e = qd.pop_front(); chk(gd == e, "word_d", gd, e); end
        end
        hold4c <= o_val4c && !rdy4c && !rst;
        hold4n <= o_val4n && !rdy4n && !rst;
        holdd  <= o_vald && !rdyd && !rst;
        p4c <= g4c;
        p4n <= g4n;
        pd  <= gd;
    end

    task automatic wait_idle(input int budget);
        int n = 0;
        while (!(o_rdy4c && o_rdy4n && o_rdyd && q4c.size() == 0 && q4n.size() == 0 && qd.size() == 0)
               && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) chk(1'b0, "idle_timeout", 64'(n), 64'(budget));
    endtask

    task automatic drive4(input int ti, input bit to_c, input bit to_n);
        wait_idle(400);
        @(posedge clk); #1;
        dat4 = tbl[ti].coef;
        val4c = to_c;
        val4n = to_n;
        for (int k = 0; k < 5; k++) begin
            if (to_c) q4c.push_back({tbl[ti].words[k], 7'(k), k == 4, 1'b0});
            if (to_n && k < 4) q4n.push_back({tbl[ti].words[k], 7'(k), k == 3, (k == 3) ? tbl[ti].ovf : 1'b0});
        end
        @(posedge clk); #1;
        val4c = 1'b0;
        val4n = 1'b0;
    endtask

    // Reference: full-width integer sum of coef[k] << 16k, sliced into 67 words.
    task automatic drive_d(input logic [65:0][16:0] v);
        logic [1071:0] acc;
        wait_idle(2000);
        @(posedge clk); #1;
        datd = v;
        vald = 1'b1;
        acc = '0;
        for (int k = 0; k < 66; k++) acc = acc + (1072'(v[k]) << (16 * k));
        for (int k = 0; k < 67; k++) qd.push_back({acc[16*k +: 16], 7'(k), k == 66, 1'b0});
        @(posedge clk); #1;
        vald = 1'b0;
    endtask

    task automatic rand_vec(output logic [65:0][16:0] v);
        for (int k = 0; k < 66; k++) v[k] = 17'($urandom_range(0, 131071));
    endtask

    initial begin
        logic [65:0][16:0] rv;
        int x0;
        int n;
        rst = 1'b1; rnd_en = 1'b0;
        val4c = 1'b0; val4n = 1'b0; vald = 1'b0;
        dat4 = '0; datd = '0;

        tbl[0].coef = {17'h0FFFF, 17'h0FFFF, 17'h0FFFF, 17'h10000};
        tbl[0].words = {16'h0001, 16'h0000, 16'h0000, 16'h0000, 16'h0000}; tbl[0].ovf = 1'b1;
        tbl[1].coef = {17'h1FFFF, 17'h1FFFF, 17'h1FFFF, 17'h1FFFF};
        tbl[1].words = {16'h0002, 16'h0001, 16'h0001, 16'h0000, 16'hFFFF}; tbl[1].ovf = 1'b1;
        tbl[2].coef = {17'h0FFFF, 17'h0FFFF, 17'h0FFFF, 17'h0FFFF};
        tbl[2].words = {16'h0000, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF}; tbl[2].ovf = 1'b0;
        tbl[3].coef = '0;
        tbl[3].words = '0; tbl[3].ovf = 1'b0;
        tbl[4].coef = {17'h00001, 17'h18000, 17'h0ABCD, 17'h12345};
        tbl[4].words = {16'h0000, 16'h0002, 16'h8000, 16'hABCE, 16'h2345}; tbl[4].ovf = 1'b0;

        repeat (3) @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk({o_rdy4c, o_val4c, g4c} == 27'h4000000, "reset_4c", {o_rdy4c, o_val4c, g4c}, 27'h4000000);
        chk({o_rdy4n, o_val4n, g4n} == 27'h4000000, "reset_4n", {o_rdy4n, o_val4n, g4n}, 27'h4000000);
        chk({o_rdyd, o_vald, gd} == 27'h4000000, "reset_d", {o_rdyd, o_vald, gd}, 27'h4000000);

        // Ripple vector with latency checks: word 0 at t+1, last at t+N (t+N+1 with carry word).
        drive4(0, 1'b1, 1'b1);
        @(negedge clk);
        chk(o_val4c && o_idx4c == 0 && o_val4n && o_idx4n == 0, "lat_first", {o_val4c, o_idx4c, o_val4n, o_idx4n}, 8'h88);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk(o_val4n && o_last4n && o_idx4n == 3, "lat_last_n", {o_val4n, o_last4n, o_idx4n}, 5'h1B);
        @(posedge clk);
        @(negedge clk);
        chk(o_val4c && o_last4c && o_idx4c == 4, "lat_last_c", {o_val4c, o_last4c, o_idx4c}, 5'h1C);
        @(posedge clk);
        @(negedge clk);
        chk(o_rdy4c && !o_val4c, "idle_after", {o_rdy4c, o_val4c}, 2'b10);

        // Table vectors under random backpressure.
        rnd_en = 1'b1;
        for (int i = 0; i < 5; i++) drive4(i, 1'b1, 1'b1);
        wait_idle(400);
        rnd_en = 1'b0;

        // Busy ignore: a second vector offered during streaming must be dropped.
        drive4(1, 1'b1, 1'b0);
        dat4 = tbl[2].coef;
        val4c = 1'b1;
        @(negedge clk);
        chk(!o_rdy4c && o_val4c, "busy_rdy", {o_rdy4c, o_val4c}, 2'b01);
        @(posedge clk); #1;
        @(negedge clk);
        chk(!o_rdy4c && o_val4c, "busy_rdy2", {o_rdy4c, o_val4c}, 2'b01);
        val4c = 1'b0;
        drive4(2, 1'b1, 1'b0);
        wait_idle(400);

        // Reset mid-stream on the default instance, then a clean restart.
        rand_vec(rv);
        drive_d(rv);
        n = 0;
        while (!(o_vald && o_idxd == 7'd10) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk(1'b0, "reach_idx10", 64'(o_idxd), 64'd10);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        qd.delete();
        @(negedge clk);
        chk({o_rdyd, o_vald, gd} == 27'h4000000, "rst_mid", {o_rdyd, o_vald, gd}, 27'h4000000);
        rand_vec(rv);
        drive_d(rv);
        wait_idle(2000);

        // Backpressure on the default instance: exactly 67 words reassemble the model.
        rnd_en = 1'b1;
        x0 = xfer_d;
        rand_vec(rv);
        drive_d(rv);
        wait_idle(2000);
        chk(xfer_d - x0 == 67, "word_count", 64'(xfer_d - x0), 64'd67);
        rand_vec(rv);
        drive_d(rv);
        wait_idle(2000);
        rnd_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
